// File: rtl/pe_chain_ctrl.sv
// ---------------------------------------------------------------------------
// pe_chain_ctrl
//
// Controller for a linear chain of N_PE processing elements. It loads
// per-PE weights, streams one frame of pixels into the head of the chain,
// and tracks which chain output cycles carry real results. The tracking
// uses a tag shift register that mirrors the chain latency. Results are
// forwarded to an AXI-stream style output with back-pressure.
//
// Handshake rule for every valid/ready pair in this block: a transfer
// happens on a rising clk edge where valid and ready are both 1. Once the
// sender raises valid, it holds valid and its payload stable until that
// transfer happens.
//
// Ports
//   clk, rstn          clock; synchronous active-low reset
//   start, cfg_len     frame start pulse and pixel count (sampled in IDLE)
//   w_valid/w_ready    weight load handshake, w_data is written to slice widx
//   s_tvalid/s_tready  pixel input stream, s_tdata is the pixel
//   pe_en              chain advance enable; the chain holds when 0
//   pe_data            pixel driven into the first PE
//   pe_weights         weight bus, PE k uses slice k
//   chain_result       result from the last PE
//   m_tvalid/m_tready  result output stream with m_tdata and m_tlast
//   busy               controller is not IDLE
//   done               one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module pe_chain_ctrl #(
    parameter int N_PE         = 9,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 1,
    parameter int PIPE_LAT     = N_PE + 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [15:0]                          cfg_len,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    input  logic [WEIGHT_WIDTH-1:0]              w_data,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    input  logic [DATA_WIDTH-1:0]                s_tdata,
    output logic                                 pe_en,
    output logic [DATA_WIDTH-1:0]                pe_data,
    output logic [N_PE*WEIGHT_WIDTH-1:0]         pe_weights,
    input  logic [DATA_WIDTH+WEIGHT_WIDTH:0]     chain_result,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [DATA_WIDTH+WEIGHT_WIDTH:0]     m_tdata,
    output logic                                 m_tlast,
    output logic                                 busy,
    output logic                                 done
);

    localparam int WIDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(N_PE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t               state;
    logic [WIDX_W-1:0]    widx;
    logic [15:0]          remaining;
    logic [PIPE_LAT-1:0]  tag_valid;
    logic [PIPE_LAT-1:0]  tag_last;

    // Held low for the first cycle after reset so that every output reads 0
    // right after a reset edge, including w_ready, which is otherwise high
    // in IDLE.
    logic                 out_live;

    logic                 can_adv;
    logic                 pix_accept;
    logic                 w_fire;
    logic                 in_last;
    logic [PIPE_LAT:0]    valid_ext;
    logic [PIPE_LAT:0]    last_ext;
    logic [PIPE_LAT-1:0]  valid_next;
    logic [PIPE_LAT-1:0]  last_next;

    // The tail of the tag pipe lines up with the chain output. So the tail
    // bits qualify whatever the last PE is presenting right now.
    assign m_tvalid = tag_valid[PIPE_LAT-1];
    assign m_tlast  = tag_last[PIPE_LAT-1];
    assign m_tdata  = chain_result;

    // The chain may advance only if the result at its tail is absent or is
    // being taken this cycle. Otherwise the result would be overwritten.
    assign can_adv  = !m_tvalid || m_tready;

    assign s_tready   = (state == ST_STREAM) && can_adv;
    assign pix_accept = s_tvalid && s_tready;
    assign w_ready    = out_live && ((state == ST_IDLE) || (state == ST_LOAD_W));
    assign w_fire     = w_valid && w_ready;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign in_last    = pix_accept && (remaining == 16'd1);

    always_comb begin
        pe_en   = 1'b0;
        pe_data = '0;
        case (state)
            ST_STREAM: begin
                pe_en = pix_accept;
                if (pix_accept) begin
                    pe_data = s_tdata;
                end
            end
            // Bubbles (pe_data=0, zero tags) push the remaining results out.
            ST_DRAIN: pe_en = can_adv;
            default:  pe_en = 1'b0;
        endcase
    end

    // Next tag contents. Entry 0 is the head and entry PIPE_LAT-1 is the
    // tail. The extra bit keeps the slicing legal even when PIPE_LAT is 1.
    assign valid_ext  = {tag_valid, pix_accept};
    assign last_ext   = {tag_last, in_last};
    assign valid_next = pe_en ? valid_ext[PIPE_LAT-1:0] : tag_valid;
    assign last_next  = pe_en ? last_ext[PIPE_LAT-1:0]  : tag_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            widx       <= '0;
            remaining  <= '0;
            tag_valid  <= '0;
            tag_last   <= '0;
            pe_weights <= '0;
            out_live   <= 1'b0;
        end else begin
            out_live  <= 1'b1;
            tag_valid <= valid_next;
            tag_last  <= last_next;

            // widx is 0 whenever the block is IDLE. So a handshake in IDLE
            // writes slice 0, and a handshake in LOAD_W continues from there.
            if (w_fire) begin
                for (int k = 0; k < N_PE; k++) begin
                    if (widx == WIDX_W'(k)) begin
                        pe_weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= w_data;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (w_fire) begin
                        if (widx == WIDX_LAST) begin
                            widx  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            widx  <= widx + 1'b1;
                            state <= ST_LOAD_W;
                        end
                    end else if (start) begin
                        remaining <= cfg_len;
                        state     <= (cfg_len == 16'd0) ? ST_DONE : ST_STREAM;
                    end
                end

                ST_LOAD_W: begin
                    if (w_fire) begin
                        if (widx == WIDX_LAST) begin
                            widx  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            widx  <= widx + 1'b1;
                        end
                    end
                end

                ST_STREAM: begin
                    if (pix_accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_DRAIN;
                        end
                    end
                end

                // Leave on the cycle that retires the final valid tag. So
                // the chain is enabled exactly PIPE_LAT times while draining.
                ST_DRAIN: begin
                    if (valid_next == '0) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_chain_ctrl
//
// Bench for pe_chain_ctrl. A simple delay-line stub stands in for the PE
// chain: it advances on pe_en and returns the pixel together with the
// weight in slice 0. The reference model is a queue of the pixels that were
// accepted. Each frame must return the same pixels in order, with m_tlast
// on the cfg_len-th result and exactly one done pulse.
// ---------------------------------------------------------------------------
module tb_pe_chain_ctrl;

    localparam int N_PE = 9;
    localparam int DW   = 8;
    localparam int WW   = 1;
    localparam int PL   = N_PE + 1;
    localparam int RW   = DW + WW + 1;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start;
    logic [15:0]          cfg_len;
    logic                 w_valid;
    logic                 w_ready;
    logic [WW-1:0]        w_data;
    logic                 s_tvalid;
    logic                 s_tready;
    logic [DW-1:0]        s_tdata;
    logic                 pe_en;
    logic [DW-1:0]        pe_data;
    logic [N_PE*WW-1:0]   pe_weights;
    logic [RW-1:0]        chain_result;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [RW-1:0]        m_tdata;
    logic                 m_tlast;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0]      exp_q[$];
    logic [N_PE*WW-1:0] exp_w;
    int                 cur_len, acc_cnt, res_cnt, last_cnt, pe_cnt, done_cnt;
    bit                 prev_stall, prev_done;
    logic [RW-1:0]      held_data;
    logic               held_last;
    logic [DW-1:0]      stub [PL];

    pe_chain_ctrl #(
        .N_PE(N_PE), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .pe_en(pe_en), .pe_data(pe_data), .pe_weights(pe_weights),
        .chain_result(chain_result),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .busy(busy), .done(done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- chain stub ----------------
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < PL; i++) stub[i] <= '0;
        end else if (pe_en) begin
            for (int i = PL - 1; i > 0; i--) stub[i] <= stub[i-1];
            stub[0] <= pe_data;
        end
    end
    assign chain_result = {1'b0, pe_weights[WW-1:0], stub[PL-1]};

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, held_data);
                check("hold_last", m_tlast, held_last);
            end
            if (m_tvalid && !m_tready) begin
                check("stall_pe_en", pe_en, 0);
                check("stall_s_tready", s_tready, 0);
            end
            if (s_tvalid && s_tready) begin
                exp_q.push_back(s_tdata);
                acc_cnt++;
            end
            if (pe_en) pe_cnt++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    logic [DW-1:0] pix;
                    logic [RW-1:0] e;
                    pix = exp_q.pop_front();
                    e   = {1'b0, exp_w[WW-1:0], pix};
                    check("m_tdata", m_tdata, e);
                    check("m_tlast", m_tlast, (res_cnt + 1 == cur_len) ? 1 : 0);
                end
                res_cnt++;
                if (m_tlast) last_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (prev_done) check("done_width", 2, 1);
            end
            prev_done  = done;
            prev_stall = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_last  = m_tlast;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        s_tdata = DW'($urandom);
    endtask

    task automatic load_weights(input logic [N_PE*WW-1:0] wv);
        for (int k = 0; k < N_PE; k++) begin
            w_valid = 1'b1;
            w_data  = wv[k*WW +: WW];
            @(negedge clk);
            check("w_ready_load", w_ready, 1);
            tick();
        end
        w_valid = 1'b0;
        exp_w   = wv;
        #1;
        check("pe_weights", pe_weights, exp_w);
        check("busy_after_load", busy, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: one 5-cycle stall on first result
    task automatic run_frame(input int len, input int mode, input bit inject);
        int stall_left;
        bit stalled;
        stall_left = 0;
        stalled    = 1'b0;
        cur_len  = len;
        acc_cnt  = 0; res_cnt = 0; last_cnt = 0; pe_cnt = 0; done_cnt = 0;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        start    = 1'b1;
        cfg_len  = 16'(len);
        tick();
        start = 1'b0;
        if (len == 0) begin
            @(negedge clk);
            check("done_after_zero_len", done, 1);
        end
        for (int it = 0; it < 2000; it++) begin
            if (done_cnt > 0) break;
            case (mode)
                1: m_tready = ($urandom_range(0, 99) < 70);
                2: begin
                    if (stall_left > 0) begin
                        m_tready = 1'b0;
                        stall_left--;
                    end else if (!stalled && m_tvalid) begin
                        stalled    = 1'b1;
                        m_tready   = 1'b0;
                        stall_left = 4;
                    end else begin
                        m_tready = 1'b1;
                    end
                end
                default: m_tready = 1'b1;
            endcase
            if (inject && it == 2) begin
                start   = 1'b1;
                cfg_len = 16'd3;
                w_valid = 1'b1;
                w_data  = '1;
                @(negedge clk);
                check("w_ready_in_stream", w_ready, 0);
                tick();
                start   = 1'b0;
                w_valid = 1'b0;
            end else begin
                tick();
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        check("accepted", acc_cnt, len);
        check("results", res_cnt, len);
        check("tlast_count", last_cnt, (len > 0) ? 1 : 0);
        check("done_count", done_cnt, 1);
        check("pe_en_cycles", pe_cnt, (len == 0) ? 0 : len + PL);
        check("queue_empty", exp_q.size(), 0);
        check("busy_after_frame", busy, 0);
        check("weights_kept", pe_weights, exp_w);
        if (mode == 2) check("stall_seen", stalled, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pe_en"}, pe_en, 0);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_w_ready"}, w_ready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pe_data"}, pe_data, 0);
        check({tag, "_pe_weights"}, pe_weights, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b0; start = 1'b0; cfg_len = '0; w_valid = 1'b0; w_data = '0;
        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1; exp_w = '0;
        cur_len = 0; acc_cnt = 0; res_cnt = 0; last_cnt = 0; pe_cnt = 0; done_cnt = 0;
        tick();
        tick();
        @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;
        tick();
        tick();
        check("w_ready_idle", w_ready, 1);
        check("busy_idle", busy, 0);

        load_weights(9'b011101101);
        run_frame(4, 0, 1'b0);
        run_frame(5, 2, 1'b0);
        run_frame(0, 0, 1'b0);
        run_frame(8, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) load_weights(N_PE'($urandom));
            run_frame($urandom_range(1, 20), 1, 1'b0);
        end

        // Reset two cycles into DRAIN.
        cur_len = 6; acc_cnt = 0; res_cnt = 0; done_cnt = 0;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        start    = 1'b1;
        cfg_len  = 16'd6;
        tick();
        start = 1'b0;
        for (int it = 0; it < 100; it++) begin
            if (acc_cnt == 6) break;
            tick();
        end
        check("drain_reached", acc_cnt, 6);
        tick();
        rstn = 1'b0;
        s_tvalid = 1'b0;
        tick();
        @(negedge clk);
        check_outputs_zero("mid_reset");
        rstn = 1'b1;
        exp_w = '0;
        res_cnt = 0; done_cnt = 0;
        for (int it = 0; it < 30; it++) tick();
        check("no_done_after_reset", done_cnt, 0);
        check("no_result_after_reset", res_cnt, 0);
        run_frame(5, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got expired, expected finish");
        $fatal(1);
    end

endmodule
